// File: rtl/text_cell_renderer.sv
// rtl/text_cell_renderer.sv - character cell renderer driving a pixel-plot VGA adapter
//
// Accepts characters over a valid/ready handshake, latches the external glyph
// decoder bitmap and plots one pixel per cycle into the cursor cell. Handles
// newline, backspace, end-of-screen row clear and a full-screen clear request.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   char_valid/char_ready        character handshake, ascii_in is the code offered
//   glyph_code                   latched code for the external glyph decoder
//   glyph_bits                   decoder bitmap, MSB = top-left, row-major
//   clear_req                    clear screen and home cursor (sampled in IDLE)
//   fg_colour, bg_colour         pixel colours, sampled per pixel
//   x_out, y_out, colour_out     registered pixel write, qualified by plot
//   cur_col, cur_row             cursor position
module text_cell_renderer #(
  parameter int GLYPH_W = 8,
  parameter int GLYPH_H = 16,
  parameter int COLS    = 40,
  parameter int ROWS    = 15,
  parameter int X_W     = 9,
  parameter int Y_W     = 8,
  localparam int NPIX   = GLYPH_W * GLYPH_H,
  localparam int CW     = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int RW     = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            char_valid,
  output logic            char_ready,
  input  logic [6:0]      ascii_in,
  output logic [6:0]      glyph_code,
  input  logic [NPIX-1:0] glyph_bits,
  input  logic            clear_req,
  input  logic [2:0]      fg_colour,
  input  logic [2:0]      bg_colour,
  output logic [X_W-1:0]  x_out,
  output logic [Y_W-1:0]  y_out,
  output logic [2:0]      colour_out,
  output logic            plot,
  output logic [CW-1:0]   cur_col,
  output logic [RW-1:0]   cur_row
);

  typedef enum logic [2:0] {IDLE, LOAD, DRAW, CLEAR, ADVANCE} state_t;

  localparam logic [4:0]    PX_LAST  = 5'(GLYPH_W - 1);
  localparam logic [5:0]    PY_LAST  = 6'(GLYPH_H - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

  state_t          state_q;
  logic [NPIX-1:0] glyph_q;   // MSB always holds the bit of the next pixel to emit
  logic [4:0]      px_q;
  logic [5:0]      py_q;
  logic [CW-1:0]   cx_q;      // cell currently being drawn/cleared
  logic [RW-1:0]   cy_q;
  logic            blank_q;   // DRAW paints background only (backspace)
  logic            full_q;    // CLEAR covers every row, not just row 0
  logic            nl_q;      // ADVANCE performs a newline rather than a column step

  logic            px_end, cell_end, row_end, last_cell, printable;
  logic [4:0]      px_nxt;
  logic [5:0]      py_nxt;
  logic [CW-1:0]   cx_nxt, bs_col;
  logic [RW-1:0]   cy_nxt, bs_row;

  function automatic logic [X_W-1:0] pix_x(input logic [CW-1:0] c, input logic [4:0] px);
    logic [31:0] t;
    t = 32'(c) * 32'(GLYPH_W) + 32'(px);
    return t[X_W-1:0];
  endfunction

  function automatic logic [Y_W-1:0] pix_y(input logic [RW-1:0] r, input logic [5:0] py);
    logic [31:0] t;
    t = 32'(r) * 32'(GLYPH_H) + 32'(py);
    return t[Y_W-1:0];
  endfunction

  // clear_req wins over a simultaneous character offer
  assign char_ready = (state_q == IDLE) && !clear_req;

  always_comb begin
    px_end    = (px_q == PX_LAST);
    cell_end  = px_end && (py_q == PY_LAST);
    row_end   = (cx_q == COL_LAST);
    px_nxt    = px_end ? '0 : px_q + 1'b1;
    py_nxt    = cell_end ? '0 : (px_end ? py_q + 1'b1 : py_q);
    cx_nxt    = cell_end ? (row_end ? '0 : cx_q + 1'b1) : cx_q;
    cy_nxt    = (cell_end && row_end) ? cy_q + 1'b1 : cy_q;
    last_cell = row_end && (!full_q || (cy_q == ROW_LAST));
    printable = (glyph_code >= 7'h20) && (glyph_code <= 7'h7E);
    bs_col    = cur_col;
    bs_row    = cur_row;
    if (cur_col != '0) begin
      bs_col = cur_col - 1'b1;
    end else if (cur_row != '0) begin
      bs_col = COL_LAST;
      bs_row = cur_row - 1'b1;
    end
  end

  // Pixel outputs are registered on the edge that enters/steps DRAW or CLEAR,
  // so plot is high exactly during the cycles spent in those states.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      plot       <= 1'b0;
      x_out      <= '0;
      y_out      <= '0;
      colour_out <= '0;
      glyph_code <= '0;
      cur_col    <= '0;
      cur_row    <= '0;
      glyph_q    <= '0;
      px_q       <= '0;
      py_q       <= '0;
      cx_q       <= '0;
      cy_q       <= '0;
      blank_q    <= 1'b0;
      full_q     <= 1'b0;
      nl_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (clear_req) begin
            full_q     <= 1'b1;
            cx_q       <= '0;
            cy_q       <= '0;
            px_q       <= '0;
            py_q       <= '0;
            plot       <= 1'b1;
            x_out      <= '0;
            y_out      <= '0;
            colour_out <= bg_colour;
            state_q    <= CLEAR;
          end else if (char_valid) begin
            glyph_code <= ascii_in;
            state_q    <= LOAD;
          end
        end
        LOAD: begin
          px_q <= '0;
          py_q <= '0;
          if (printable) begin
            cx_q       <= cur_col;
            cy_q       <= cur_row;
            blank_q    <= 1'b0;
            glyph_q    <= glyph_bits << 1;
            plot       <= 1'b1;
            x_out      <= pix_x(cur_col, 5'd0);
            y_out      <= pix_y(cur_row, 6'd0);
            colour_out <= glyph_bits[NPIX-1] ? fg_colour : bg_colour;
            state_q    <= DRAW;
          end else if (glyph_code == 7'h0A) begin
            nl_q    <= 1'b1;
            state_q <= ADVANCE;
          end else if (glyph_code == 7'h08) begin
            cur_col    <= bs_col;
            cur_row    <= bs_row;
            cx_q       <= bs_col;
            cy_q       <= bs_row;
            blank_q    <= 1'b1;
            plot       <= 1'b1;
            x_out      <= pix_x(bs_col, 5'd0);
            y_out      <= pix_y(bs_row, 6'd0);
            colour_out <= bg_colour;
            state_q    <= DRAW;
          end else begin
            state_q <= IDLE;
          end
        end
        DRAW: begin
          if (cell_end) begin
            plot    <= 1'b0;
            state_q <= blank_q ? IDLE : ADVANCE;
          end else begin
            px_q       <= px_nxt;
            py_q       <= py_nxt;
            glyph_q    <= glyph_q << 1;
            x_out      <= pix_x(cx_q, px_nxt);
            y_out      <= pix_y(cy_q, py_nxt);
            colour_out <= (!blank_q && glyph_q[NPIX-1]) ? fg_colour : bg_colour;
          end
        end
        ADVANCE: begin
          nl_q <= 1'b0;
          if (nl_q || (cur_col == COL_LAST)) begin
            cur_col <= '0;
            if (cur_row == ROW_LAST) begin
              // screen full: wrap to row 0 and wipe it before accepting more
              cur_row    <= '0;
              full_q     <= 1'b0;
              cx_q       <= '0;
              cy_q       <= '0;
              px_q       <= '0;
              py_q       <= '0;
              plot       <= 1'b1;
              x_out      <= '0;
              y_out      <= '0;
              colour_out <= bg_colour;
              state_q    <= CLEAR;
            end else begin
              cur_row <= cur_row + 1'b1;
              state_q <= IDLE;
            end
          end else begin
            cur_col <= cur_col + 1'b1;
            state_q <= IDLE;
          end
        end
        CLEAR: begin
          if (cell_end && last_cell) begin
            plot    <= 1'b0;
            cur_col <= '0;
            cur_row <= '0;
            state_q <= IDLE;
          end else begin
            px_q       <= px_nxt;
            py_q       <= py_nxt;
            cx_q       <= cx_nxt;
            cy_q       <= cy_nxt;
            x_out      <= pix_x(cx_nxt, px_nxt);
            y_out      <= pix_y(cy_nxt, py_nxt);
            colour_out <= bg_colour;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_text_cell_renderer.sv
// tb/tb_text_cell_renderer.sv - self-checking bench for text_cell_renderer
module tb_text_cell_renderer;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         char_valid = 1'b0;
  logic         clear_req = 1'b0;
  logic [6:0]   ascii_in = '0;
  logic [127:0] glyph_bits = '0;
  logic [2:0]   fg_colour = '0;
  logic [2:0]   bg_colour = '0;
  logic         char_ready;
  logic [6:0]   glyph_code;
  logic [8:0]   x_out;
  logic [7:0]   y_out;
  logic [2:0]   colour_out;
  logic         plot;
  logic [5:0]   cur_col;
  logic [3:0]   cur_row;

  text_cell_renderer dut (
    .clk(clk), .reset_n(reset_n), .char_valid(char_valid), .char_ready(char_ready),
    .ascii_in(ascii_in), .glyph_code(glyph_code), .glyph_bits(glyph_bits),
    .clear_req(clear_req), .fg_colour(fg_colour), .bg_colour(bg_colour),
    .x_out(x_out), .y_out(y_out), .colour_out(colour_out), .plot(plot),
    .cur_col(cur_col), .cur_row(cur_row)
  );

  always #5 clk = ~clk;

  typedef struct { int x; int y; logic [2:0] c; } pix_t;
  typedef struct {
    logic [6:0] code; logic [127:0] glyph; logic [2:0] fg; logic [2:0] bg;
    int ecol; int erow; int eplots; int ebusy; int xmin; int xmax; int ymin; int ymax;
  } vec_t;

  pix_t       exp_q[$];
  int         total = 0, bad = 0;
  int         op_id = 0, seen_op = 0;
  int         plot_count = 0, fg_count = 0, pix_err = 0;
  int         xmin = 0, xmax = 0, ymin = 0, ymax = 0;
  logic [2:0] cur_fg = '0;
  int         mcol = 0, mrow = 0;

  // Scoreboard side: every plotted pixel is popped and compared against the model
  always @(negedge clk) begin
    pix_t e;
    if (op_id != seen_op) begin
      seen_op = op_id; plot_count = 0; fg_count = 0; pix_err = 0;
      xmin = 1 << 30; xmax = -1; ymin = 1 << 30; ymax = -1;
    end
    if (!reset_n) exp_q.delete();
    else if (plot) begin
      plot_count++;
      if (colour_out == cur_fg) fg_count++;
      if (int'(x_out) < xmin) xmin = int'(x_out);
      if (int'(x_out) > xmax) xmax = int'(x_out);
      if (int'(y_out) < ymin) ymin = int'(y_out);
      if (int'(y_out) > ymax) ymax = int'(y_out);
      if (exp_q.size() == 0) pix_err++;
      else begin
        e = exp_q.pop_front();
        if (e.x != int'(x_out) || e.y != int'(y_out) || e.c != colour_out) pix_err++;
      end
    end
  end

  task automatic check(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic push_cell(input int col, input int row, input logic [127:0] g,
                           input bit blank, input logic [2:0] f, input logic [2:0] b);
    pix_t e;
    for (int p = 0; p < 128; p++) begin
      e.x = col * 8 + p % 8;
      e.y = row * 16 + p / 8;
      e.c = (!blank && g[127-p]) ? f : b;
      exp_q.push_back(e);
    end
  endtask

  task automatic model_newline(input logic [2:0] b);
    if (mrow == 14) begin
      mrow = 0;
      for (int c = 0; c < 40; c++) push_cell(c, 0, '0, 1'b1, 3'd0, b);
    end else mrow++;
  endtask

  task automatic model_char(input logic [6:0] code, input logic [127:0] g,
                            input logic [2:0] f, input logic [2:0] b);
    if (code >= 7'h20 && code <= 7'h7E) begin
      push_cell(mcol, mrow, g, 1'b0, f, b);
      if (mcol == 39) begin mcol = 0; model_newline(b); end
      else mcol++;
    end else if (code == 7'h0A) begin
      mcol = 0; model_newline(b);
    end else if (code == 7'h08) begin
      if (mcol > 0) mcol--;
      else if (mrow > 0) begin mcol = 39; mrow--; end
      push_cell(mcol, mrow, '0, 1'b1, f, b);
    end
  endtask

  task automatic wait_idle(output int busy);
    bit done;
    busy = 0; done = 0;
    while (!done && busy < 90000) begin
      @(negedge clk); #1;
      if (char_ready) done = 1; else busy++;
    end
    check("op_done", int'(done), 1);
  endtask

  task automatic send(input logic [6:0] code, input logic [127:0] g,
                      input logic [2:0] f, input logic [2:0] b, output int busy);
    @(negedge clk);
    op_id++; cur_fg = f;
    ascii_in = code; glyph_bits = g; fg_colour = f; bg_colour = b;
    model_char(code, g, f, b);
    check("ready_in_idle", int'(char_ready), 1);
    char_valid = 1'b1;
    @(posedge clk); #1;
    char_valid = 1'b0; ascii_in = 7'h00;
    wait_idle(busy);
  endtask

  function automatic vec_t mk(input logic [6:0] code, input logic [127:0] g,
                              input logic [2:0] f, input logic [2:0] b,
                              input int ecol, input int erow, input int eplots, input int ebusy,
                              input int x0, input int x1, input int y0, input int y1);
    vec_t v;
    v.code = code; v.glyph = g; v.fg = f; v.bg = b;
    v.ecol = ecol; v.erow = erow; v.eplots = eplots; v.ebusy = ebusy;
    v.xmin = x0; v.xmax = x1; v.ymin = y0; v.ymax = y1;
    return v;
  endfunction

  vec_t vt[$];

  initial begin
    int busy, err_sum, busy_sum, n;
    logic [127:0] g;

    // table starts with the cursor at (0,1), after the 40-character row
    vt.push_back(mk(7'h08, '0, 3'd1, 3'd4, 39, 0, 128, 129, 312, 319, 0, 15));
    vt.push_back(mk(7'h0A, '0, 3'd1, 3'd4, 0, 1, 0, 2, 0, 0, 0, 0));
    for (int r = 2; r <= 14; r++) vt.push_back(mk(7'h0A, '0, 3'd1, 3'd4, 0, r, 0, 2, 0, 0, 0, 0));
    vt.push_back(mk(7'h0A, '0, 3'd1, 3'd6, 0, 0, 5120, 5122, 0, 319, 0, 15));
    vt.push_back(mk(7'h08, '0, 3'd1, 3'd3, 0, 0, 128, 129, 0, 7, 0, 15));
    vt.push_back(mk(7'h07, '0, 3'd1, 3'd3, 0, 0, 0, 1, 0, 0, 0, 0));
    vt.push_back(mk(7'h68, 128'h0123456789ABCDEF_FEDCBA9876543210, 3'd1, 3'd6, 1, 0, 128, 130, 0, 7, 0, 15));
    vt.push_back(mk(7'h7F, '1, 3'd1, 3'd6, 1, 0, 0, 1, 0, 0, 0, 0));
    vt.push_back(mk(7'h20, '1, 3'd7, 3'd0, 2, 0, 128, 130, 8, 15, 0, 15));

    // reset state
    repeat (3) @(negedge clk);
    check("rst_plot", int'(plot), 0);
    check("rst_x", int'(x_out), 0);
    check("rst_y", int'(y_out), 0);
    check("rst_colour", int'(colour_out), 0);
    check("rst_code", int'(glyph_code), 0);
    check("rst_col", int'(cur_col), 0);
    check("rst_row", int'(cur_row), 0);
    reset_n = 1'b1;
    #1 check("rst_ready", int'(char_ready), 1);

    // 'A' with corner pixels set
    send(7'h41, {1'b1, 126'b0, 1'b1}, 3'd5, 3'd2, busy);
    check("A_busy", busy, 130);
    check("A_plots", plot_count, 128);
    check("A_fg_pixels", fg_count, 2);
    check("A_pix_err", pix_err, 0);
    check("A_xmax", xmax, 7);
    check("A_ymax", ymax, 15);
    check("A_col", int'(cur_col), 1);
    check("A_row", int'(cur_row), 0);
    check("A_code", int'(glyph_code), 8'h41);

    // fill the rest of row 0
    err_sum = 0; busy_sum = 0;
    for (int i = 1; i < 40; i++) begin
      g = {$urandom, $urandom, $urandom, $urandom};
      send(7'(8'h21 + i), g, 3'(i), 3'(i + 3), busy);
      err_sum += pix_err + exp_q.size();
      busy_sum += busy;
    end
    check("row_pix_err", err_sum, 0);
    check("row_busy", busy_sum, 39 * 130);
    check("c40_xmin", xmin, 312);
    check("c40_xmax", xmax, 319);
    check("c40_ymax", ymax, 15);
    check("c40_col", int'(cur_col), 0);
    check("c40_row", int'(cur_row), 1);

    for (int i = 0; i < vt.size(); i++) begin
      send(vt[i].code, vt[i].glyph, vt[i].fg, vt[i].bg, busy);
      check($sformatf("v%0d_busy", i), busy, vt[i].ebusy);
      check($sformatf("v%0d_plots", i), plot_count, vt[i].eplots);
      check($sformatf("v%0d_pix_err", i), pix_err, 0);
      check($sformatf("v%0d_queue", i), exp_q.size(), 0);
      check($sformatf("v%0d_col", i), int'(cur_col), vt[i].ecol);
      check($sformatf("v%0d_row", i), int'(cur_row), vt[i].erow);
      if (vt[i].eplots > 0) begin
        check($sformatf("v%0d_xmin", i), xmin, vt[i].xmin);
        check($sformatf("v%0d_xmax", i), xmax, vt[i].xmax);
        check($sformatf("v%0d_ymin", i), ymin, vt[i].ymin);
        check($sformatf("v%0d_ymax", i), ymax, vt[i].ymax);
      end
    end

    // clear_req together with a character offer
    @(negedge clk);
    op_id++; cur_fg = 3'd7;
    fg_colour = 3'd7; bg_colour = 3'd3; ascii_in = 7'h5A;
    char_valid = 1'b1; clear_req = 1'b1;
    for (int r = 0; r < 15; r++)
      for (int c = 0; c < 40; c++) push_cell(c, r, '0, 1'b1, 3'd0, 3'd3);
    mcol = 0; mrow = 0;
    #1 check("clr_ready_low", int'(char_ready), 0);
    @(posedge clk); #1;
    char_valid = 1'b0; clear_req = 1'b0;
    wait_idle(busy);
    check("clr_busy", busy, 76800);
    check("clr_plots", plot_count, 76800);
    check("clr_pix_err", pix_err, 0);
    check("clr_queue", exp_q.size(), 0);
    check("clr_xmax", xmax, 319);
    check("clr_ymax", ymax, 239);
    check("clr_col", int'(cur_col), 0);
    check("clr_row", int'(cur_row), 0);
    check("clr_not_accepted", int'(glyph_code), 8'h20);

    // reset in the middle of a glyph draw
    @(negedge clk);
    op_id++; cur_fg = 3'd6;
    g = {$urandom, $urandom, $urandom, $urandom};
    ascii_in = 7'h42; glyph_bits = g; fg_colour = 3'd6; bg_colour = 3'd1;
    model_char(7'h42, g, 3'd6, 3'd1);
    char_valid = 1'b1;
    @(posedge clk); #1 char_valid = 1'b0;
    n = 0;
    while (plot_count < 51 && n < 1000) begin @(negedge clk); #1; n++; end
    check("mid_reached_pix50", plot_count, 51);
    check("mid_pix_err", pix_err, 0);
    check("mid_x_pix50", int'(x_out), 2);
    check("mid_y_pix50", int'(y_out), 6);
    reset_n = 1'b0;
    #1;
    check("mid_plot_async", int'(plot), 0);
    check("mid_x_async", int'(x_out), 0);
    @(posedge clk); @(posedge clk); @(negedge clk);
    reset_n = 1'b1; op_id++;
    mcol = 0; mrow = 0;
    repeat (200) @(negedge clk);
    #1;
    check("post_rst_plots", plot_count, 0);
    check("post_rst_ready", int'(char_ready), 1);
    check("post_rst_col", int'(cur_col), 0);
    check("post_rst_row", int'(cur_row), 0);
    check("post_rst_code", int'(glyph_code), 0);
    check("post_rst_queue", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/text_cell_renderer.md
TEXT_CELL_RENDERER -- requirements
Module: text_cell_renderer

Interface
REQ-001 SHALL have parameter GLYPH_W, default 8, glyph width in pixels (1..16).
REQ-002 SHALL have parameter GLYPH_H, default 16, glyph height in pixels (1..32).
REQ-003 SHALL have parameter COLS, default 40, character columns per row.
REQ-004 SHALL have parameter ROWS, default 15, character rows.
REQ-005 SHALL have parameter X_W, default 9, x coordinate width; parameter Y_W, default 8, y coordinate width.
REQ-006 SHALL use one clock; reset is asynchronous and active-low. Ports: clk  in  1  clock; reset_n  in  1  async active-low reset.
REQ-007 SHALL have char_valid  in  1  character offered.
REQ-008 SHALL have char_ready  out  1  renderer can accept a character.
REQ-009 SHALL have ascii_in  in  7  offered character code.
REQ-010 SHALL have glyph_code  out  7  code of the latched character, driving the external glyph decoder.
REQ-011 SHALL have glyph_bits  in  GLYPH_W*GLYPH_H  decoder bitmap for glyph_code, MSB = top-left pixel, row-major.
REQ-012 SHALL have clear_req  in  1  clear screen and home cursor.
REQ-013 SHALL have fg_colour, bg_colour  in  3 each  foreground/background colours.
REQ-014 SHALL have x_out  out  X_W; y_out  out  Y_W; colour_out  out  3; plot  out  1; registered pixel write to the VGA adapter.
REQ-015 SHALL have cur_col  out  clog2(COLS); cur_row  out  clog2(ROWS)  cursor position.

Function
REQ-016 SHALL implement states IDLE, LOAD, DRAW, CLEAR, ADVANCE; char_ready = 1 only in IDLE.
REQ-017 Handshake: a character is accepted on a cycle with char_valid & char_ready; ascii_in is latched into glyph_code on that edge.
REQ-018 clear_req sampled in IDLE takes priority over char_valid; char_ready SHALL be 0 in that cycle, so the character is not accepted.
REQ-019 Printable (0x20..0x7E): IDLE -> LOAD (1 cycle, glyph_bits latched) -> DRAW at the cursor cell with fg/bg colours -> ADVANCE -> IDLE.
REQ-020 DRAW SHALL emit exactly GLYPH_W*GLYPH_H consecutive cycles with plot=1, pixel index p = 0.. in row-major order: px = p mod GLYPH_W, py = p div GLYPH_W.
REQ-021 Each DRAW pixel: x_out = cur_col*GLYPH_W+px, y_out = cur_row*GLYPH_H+py. colour_out = fg_colour if latched bit (GLYPH_W*GLYPH_H-1-p) is 1, else bg_colour.
REQ-022 Printable advance: cur_col+1; at cur_col = COLS-1, set cur_col = 0 and perform newline advance.
REQ-023 Newline 0x0A: no glyph draw; perform newline advance.
REQ-024 Newline advance: cur_row+1. At cur_row = ROWS-1, wrap to row 0 and CLEAR that row (COLS*GLYPH_W*GLYPH_H bg_colour pixels, plot=1, same scan order per cell, cells left to right) before IDLE.
REQ-025 Backspace 0x08: cursor retreats. If cur_col > 0, cur_col-1; else if cur_row > 0, cur_col = COLS-1 and cur_row-1; else no move. Then DRAW the cell at the new cursor with all pixels bg_colour.
REQ-026 Any other code SHALL be accepted and discarded: return to IDLE next cycle, no plot, cursor unchanged.
REQ-027 clear_req: CLEAR all COLS*ROWS cells with bg_colour (row-major cells), then cur_col = cur_row = 0, then IDLE.
REQ-028 plot SHALL be 0 in IDLE, LOAD and ADVANCE; x_out/y_out/colour_out hold their last values when plot=0.
REQ-029 Coordinate arithmetic SHALL be computed at full width and truncated to X_W/Y_W.
REQ-030 ascii_in, glyph_bits and colours SHALL be ignored outside their sampling cycles (handshake and LOAD); colour inputs are sampled per pixel.

Reset
REQ-031 reset_n low SHALL immediately force IDLE, plot=0, x_out=0, y_out=0, colour_out=0, glyph_code=0, cur_col=0, cur_row=0, char_ready=1 on release.
REQ-032 Reset mid-DRAW or mid-CLEAR SHALL abandon the operation with no further plots; no partial state survives.

Verification (defaults: 8x16 glyphs, 40x15 cells)
REQ-033 Reset, send 'A' (0x41) with glyph_bits = 128'h8000...0001 -> char_ready drops for 130 cycles; 128 plots at x 0..7, y 0..15; fg only at (0,0) and (7,15); cur_col=1.
REQ-034 Send 40 printable characters -> 40th draws at x 312..319; then cur_col=0, cur_row=1.
REQ-035 With cur_row=14, send 0x0A -> cur_row=0, cur_col=0; 40*128 = 5120 bg plots covering y 0..15.
REQ-036 At cur_col=0, cur_row=1, send 0x08 -> cursor (39,0); 128 bg plots at x 312..319, y 0..15. At (0,0), 0x08 -> cursor stays, 128 bg plots at the origin.
REQ-037 Assert clear_req and char_valid together in IDLE -> character not accepted; 76800 bg plots; cursor (0,0). Also: send 0x07 -> no plot, char_ready back in 2 cycles.
REQ-038 Pulse reset_n low at DRAW pixel 50 -> plot=0 asynchronously; after release IDLE, cursor (0,0), no further plots.
